// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES substitution engine.
//   - state_t      : engine FSM states
//   - SBOX_ROWS    : FIPS 46-3 S1..S8 tables, one 64-bit word per (box,row);
//                    column 0 sits in the top nibble of each word
//   - lanes_legal  : accepted lane counts (1, 2, 4, 8)
//   - group_of     : 6-bit input group for box k (S1 in bits [47:42])
//   - nib_pos      : LSB position of box k's nibble in the 32-bit result
//   - sbox_lookup  : nibble for (box, 6-bit group)
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index = {box[2:0], row[1:0]}
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h74B19CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

  function automatic logic [5:0] group_of(input logic [47:0] blk, input logic [2:0] k);
    int unsigned base;
    base = 42 - 6 * 32'(k);
    return blk[base +: 6];
  endfunction

  function automatic int unsigned nib_pos(input logic [2:0] k);
    return 28 - 4 * 32'(k);
  endfunction

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
    logic [1:0]  row;
    logic [3:0]  col;
    logic [63:0] word;
    int unsigned pos;
    row  = {grp[5], grp[0]};
    col  = grp[4:1];
    word = SBOX_ROWS[{box, row}];
    pos  = 60 - 4 * 32'(col);
    return word[pos +: 4];
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: one combinational DES S-box lookup with selectable box.
//   box    : S-box index 0..7 (S1..S8)
//   grp    : 6-bit input group (outer bits = row, inner four = column)
//   nibble : 4-bit substitution output
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] grp,
  output logic [3:0] nibble
);

  always_comb begin
    nibble = sbox_lookup(box, grp);
  end

endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: applies S1..S8 to a 48-bit half-block using LANES
// physical lookups per cycle, taking PASSES = 8/LANES cycles per block.
//   clk, n_rst          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data[47:0], S1 group on top
//   out_valid/out_ready : output handshake; out_data[31:0], S1 nibble on top
//   busy                : a block is in flight or waiting to be drained
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int unsigned PASSES = 8 / LANES;
  localparam int unsigned CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_t          state;
  logic [CW-1:0]   pass_cnt;
  logic [47:0]     in_reg;
  logic [31:0]     res_reg;
  logic [31:0]     res_next;
  logic            last_pass;
  logic            accept;

  logic [2:0]      lane_box [LANES];
  logic [5:0]      lane_grp [LANES];
  logic [3:0]      lane_nib [LANES];

  // Pass p covers boxes p*LANES .. p*LANES+LANES-1.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_box[l] = 3'(32'(pass_cnt) * LANES + l);
      lane_grp[l] = group_of(in_reg, lane_box[l]);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_sbox_lut u_lut (
      .box    (lane_box[l]),
      .grp    (lane_grp[l]),
      .nibble (lane_nib[l])
    );
  end

  always_comb begin
    res_next = res_reg;
    for (int unsigned l = 0; l < LANES; l++) begin
      res_next[nib_pos(lane_box[l]) +: 4] = lane_nib[l];
    end
  end

  assign last_pass = (pass_cnt == CW'(PASSES - 1));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      pass_cnt <= '0;
      in_reg   <= '0;
      res_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_reg   <= in_data;
            pass_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_reg <= res_next;
          if (last_pass) begin
            pass_cnt <= '0;
            state    <= ST_DONE;
          end else begin
            pass_cnt <= pass_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // Draining and accepting the next word share one edge.
          if (out_ready) begin
            if (in_valid) begin
              in_reg   <= in_data;
              pass_cnt <= '0;
              state    <= ST_BUSY;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY) || (state == ST_DONE);
  assign out_data  = res_reg;

endmodule

// File: tb/tb_des_sbox_engine.sv
// tb_des_sbox_engine: directed checks of des_sbox_engine with LANES = 1, 2, 4, 8
// instantiated side by side on a shared clock and reset.
module tb_des_sbox_engine;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  busy;
  logic [47:0] in_data  [4];
  logic [31:0] out_data [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Hand-computed S-layer results (FIPS 46-3 tables).
  logic [47:0] vec_in  [7] = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'h000023000000,
                               48'h041041041041, 48'h79E79E79E79E, 48'h820820820820,
                               48'h03F03F03F03F};
  logic [31:0] vec_exp [7] = '{32'hEFA72C4D, 32'hD9CE3DCB, 32'hEFAF2C4D,
                               32'h03DDEAD1, 32'h7A8F9B17, 32'h40DA4917,
                               32'hE9AE2D4B};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for out_valid after an accepting edge; returns cycles taken.
  task automatic wait_done(input int i, output int unsigned lat);
    lat = 0;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_block(input int i, input logic [47:0] d, input logic [31:0] exp);
    int unsigned lat;
    string       sfx;
    sfx = $sformatf("[L%0d d=%h]", 1 << i, d);
    check({"idle_in_ready", sfx}, 48'(in_ready[i]), 48'd1);
    in_valid[i]  = 1'b1;
    in_data[i]   = d;
    out_ready[i] = 1'b0;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    in_data[i]  = ~d;
    check({"busy_after_accept", sfx}, 48'(busy[i]), 48'd1);
    check({"in_ready_busy", sfx}, 48'(in_ready[i]), 48'd0);
    wait_done(i, lat);
    check({"latency", sfx}, 48'(lat), 48'(8 >> i));
    check({"out_data", sfx}, 48'(out_data[i]), 48'(exp));
    check({"in_ready_done_stalled", sfx}, 48'(in_ready[i]), 48'd0);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    check({"out_valid_after_drain", sfx}, 48'(out_valid[i]), 48'd0);
    check({"busy_after_drain", sfx}, 48'(busy[i]), 48'd0);
  endtask

  initial begin
    int unsigned lat;
    n_rst     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_in_ready[%0d]", i),  48'(in_ready[i]),  48'd1);
      check($sformatf("rst_out_valid[%0d]", i), 48'(out_valid[i]), 48'd0);
      check($sformatf("rst_busy[%0d]", i),      48'(busy[i]),      48'd0);
      check($sformatf("rst_out_data[%0d]", i),  48'(out_data[i]),  48'd0);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      for (int v = 0; v < 7; v++)
        run_block(i, vec_in[v], vec_exp[v]);

    // Backpressure on LANES=2, then drain and accept on the same edge.
    in_valid[1]  = 1'b1;
    in_data[1]   = vec_in[4];
    out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    in_data[1]  = '0;
    wait_done(1, lat);
    check("bp_latency", 48'(lat), 48'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_out_data[%0d]", c),  48'(out_data[1]),  48'(vec_exp[4]));
      check($sformatf("bp_in_ready[%0d]", c),  48'(in_ready[1]),  48'd0);
      check($sformatf("bp_out_valid[%0d]", c), 48'(out_valid[1]), 48'd1);
    end
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = vec_in[6];
    #1;
    check("bp_in_ready_on_drain", 48'(in_ready[1]), 48'd1);
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    in_data[1]   = '0;
    check("bp_busy_after_drain_accept", 48'(busy[1]), 48'd1);
    check("bp_out_valid_after_drain_accept", 48'(out_valid[1]), 48'd0);
    wait_done(1, lat);
    check("bp_next_latency", 48'(lat), 48'd4);
    check("bp_next_out_data", 48'(out_data[1]), 48'(vec_exp[6]));
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Asynchronous reset during pass 3 of a LANES=1 block.
    in_valid[0] = 1'b1;
    in_data[0]  = vec_in[1];
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before_reset", 48'(busy[0]), 48'd1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 48'(out_valid[0]), 48'd0);
    check("mid_rst_out_data",  48'(out_data[0]),  48'd0);
    check("mid_rst_in_ready",  48'(in_ready[0]),  48'd1);
    check("mid_rst_busy",      48'(busy[0]),      48'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 48'(out_valid[0]), 48'd0);
    run_block(0, vec_in[3], vec_exp[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
